// File: rtl/mux_nto1_pipe_if.sv
// Bundle of request, response and error signals for mux_nto1_pipe.
// master: the side that issues requests and consumes results.
// slave:  the selector itself.
//
// Handshake rules (both the in_* and out_* channels):
//   - A transfer happens on a rising clock edge where valid && ready.
//   - valid never waits for ready. Once a request is offered, its payload is
//     sampled only on the edge where it is accepted.
//   - On the output side, out_data/out_sel stay stable while
//     out_valid && !out_ready.
interface mux_nto1_pipe_if #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int SW    = 3,
  parameter int CNT_W = 8
);
  logic [N*W-1:0]   in_data;
  logic [SW-1:0]    in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_sel;
  logic             out_valid;
  logic             out_ready;
  logic             err_sel;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  modport master (
    output in_data, in_sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_sel, out_valid, err_sel, err_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_sel, out_valid, err_sel, err_cnt
  );
endinterface

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: registered, flow-controlled N-to-1 selector.
// It captures the selected W-bit operand into an output register and echoes
// the select value with it. It also flags and counts out-of-range selects; the
// count saturates.
//
// Build option MUX_SKID_EN:
//   undefined - single output register. in_ready = !out_valid || out_ready,
//               so there is a combinational path from out_ready to in_ready.
//   defined   - adds a one-entry skid buffer. in_ready comes from a flop, so
//               there is no combinational path from out_ready to in_ready.
//               Unstalled latency is still one cycle.
//
// Parameters: N >= 2 inputs of W bits each. The select is SW bits wide and
// needs 2**SW >= N. The error counter is CNT_W bits wide.
module mux_nto1_pipe #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int SW    = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  mux_nto1_pipe_if.slave     bus
);

  // N widened by one bit so the compare also works when 2**SW == N.
  localparam logic [SW:0]      N_EXT   = (SW+1)'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [W-1:0]     sel_data;
  logic             sel_oor;
  logic             accept;
  logic             out_fire;
  logic             err_hit;

  logic [W-1:0]     out_data_q;
  logic [SW-1:0]    out_sel_q;
  logic             out_valid_q;
  logic             err_sel_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Pick the addressed operand. An out-of-range select yields an all-zero word.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.in_sel == SW'(k)) begin
        sel_data = bus.in_data[k*W +: W];
      end
    end
  end

  assign sel_oor  = ({1'b0, bus.in_sel} >= N_EXT);
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign err_hit  = accept && sel_oor;

`ifdef MUX_SKID_EN

  logic [W-1:0]  skid_data_q;
  logic [SW-1:0] skid_sel_q;
  logic          skid_valid_q;
  logic          in_ready_q;

  // Output register. When it is free or issuing, it reloads from the skid
  // entry first (older data), otherwise from a fresh accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_data_q  <= skid_data_q;
        out_sel_q   <= skid_sel_q;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_data_q  <= sel_data;
        out_sel_q   <= bus.in_sel;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Skid entry. It fills on an accept while the output is stalled, and drains
  // into the output on the cycle the output moves on.
  // in_ready is registered and equals "skid empty".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (skid_valid_q && (!out_valid_q || out_fire)) begin
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (accept && out_valid_q && !out_fire) begin
      skid_data_q  <= sel_data;
      skid_sel_q   <= bus.in_sel;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign bus.in_ready = in_ready_q;

`else

  // Single output register. It loads on accept and empties once issued with
  // nothing behind it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_data_q  <= sel_data;
      out_sel_q   <= bus.in_sel;
      out_valid_q <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // A new request fits when the register is empty or is issuing this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;

`endif

  // Sticky error flag and saturating counter. A clear in the same cycle as an
  // accepted error leaves exactly that one error recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sel_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_sel_q <= err_hit;
      err_cnt_q <= err_hit ? CNT_ONE : '0;
    end else if (err_hit) begin
      err_sel_q <= 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_q <= err_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err_sel   = err_sel_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe. It runs directed checks (reset, back-to-back
// selects, stall, errors, saturation) and then random valid/ready traffic.
// Every output is checked against a queue-based reference model.
module tb_mux_nto1_pipe;
  localparam int N     = 5;
  localparam int W     = 32;
  localparam int SW    = 3;
  localparam int CNT_W = 8;
  localparam int WW    = W + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mux_nto1_pipe_if #(.N(N), .W(W), .SW(SW), .CNT_W(CNT_W)) bus ();

  mux_nto1_pipe #(.N(N), .W(W), .SW(SW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  logic [WW-1:0]    exp_q[$];
  logic [W-1:0]     in_words [N];
  int               m_cnt;
  logic             m_sel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference selector: the addressed word, or zero when the select is beyond
  // the last input. The select value is echoed either way.
  function automatic logic [WW-1:0] ref_word(input logic [SW-1:0] s);
    int idx;
    idx = int'(s);
    if (idx < N) return {in_words[idx], s};
    return {{W{1'b0}}, s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pack_words();
    for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = in_words[k];
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic r, input logic c);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.out_ready = r;
    bus.err_clr   = c;
    pack_words();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- input monitor + error model ----------------
  // The checks see the DUT state up to the last edge. After that, the request
  // being taken at the next edge is folded into the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_sel = 1'b0;
    end else begin
      check("err_cnt_model", 64'(bus.err_cnt), 64'(m_cnt));
      check("err_sel_model", 64'(bus.err_sel), 64'(m_sel));
      if (bus.in_valid && bus.in_ready) begin
        logic hit;
        exp_q.push_back(ref_word(bus.in_sel));
        hit = (int'(bus.in_sel) >= N);
        if (bus.err_clr) begin
          m_sel = hit;
          m_cnt = hit ? 1 : 0;
        end else if (hit) begin
          m_sel = 1'b1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
      end else if (bus.err_clr) begin
        m_sel = 1'b0;
        m_cnt = 0;
      end
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  logic          prev_stall;
  logic [WW-1:0] prev_word;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_word", 64'({bus.out_data, bus.out_sel}), 64'(prev_word));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL out_unexpected: got %0h expected nothing", {bus.out_data, bus.out_sel});
        end else begin
          logic [WW-1:0] e;
          e = exp_q.pop_front();
          check("out_word", 64'({bus.out_data, bus.out_sel}), 64'(e));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_data, bus.out_sel};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int budget;
    for (int k = 0; k < N; k++) in_words[k] = '0;
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) cyc();

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_sel", 64'(bus.out_sel), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_err_sel", 64'(bus.err_sel), 64'(0));
    check("rst_err_cnt", 64'(bus.err_cnt), 64'(0));
    reset_n = 1'b1;
    cyc();

    // Back-to-back selects 0..4, one-cycle latency
    for (int k = 0; k < N; k++) in_words[k] = 32'hA0 + k;
    for (int k = 0; k <= N; k++) begin
      if (k > 0) begin
        check("lat_valid", 64'(bus.out_valid), 64'(1));
        check("lat_sel", 64'(bus.out_sel), 64'(k - 1));
        check("lat_data", 64'(bus.out_data), 64'(32'hA0 + k - 1));
      end
      if (k < N) drive(1'b1, SW'(k), 1'b1, 1'b0);
      else       drive(1'b0, '0, 1'b1, 1'b0);
      cyc();
    end
    repeat (2) cyc();

    // Stall: the output holds A1 for three cycles
    drive(1'b1, SW'(1), 1'b1, 1'b0);
    cyc();
    drive(1'b1, SW'(2), 1'b0, 1'b0);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.in_ready) begin
        acc++;
        cyc();
        drive(1'b1, SW'(3), 1'b0, 1'b0);
      end else begin
        cyc();
      end
      check("stall_data", 64'(bus.out_data), 64'(32'hA1));
    end
`ifdef MUX_SKID_EN
    check("stall_accepts", 64'(acc), 64'(1));
`else
    check("stall_accepts", 64'(acc), 64'(0));
`endif
    #1;
    check("stall_in_ready", 64'(bus.in_ready), 64'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (3) cyc();

    // Out-of-range selects 5, 6, 7, then a clear together with one more error
    drive(1'b0, '0, 1'b1, 1'b1);
    cyc();
    for (int s = 5; s <= 7; s++) begin
      drive(1'b1, SW'(s), 1'b1, 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    check("oor_data", 64'(bus.out_data), 64'(0));
    check("oor_sel", 64'(bus.out_sel), 64'(7));
    check("oor_err_sel", 64'(bus.err_sel), 64'(1));
    check("oor_err_cnt", 64'(bus.err_cnt), 64'(3));
    drive(1'b1, SW'(7), 1'b1, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("clr_err_cnt", 64'(bus.err_cnt), 64'(1));
    check("clr_err_sel", 64'(bus.err_sel), 64'(1));
    cyc();

    // Saturation: 260 out-of-range accepts leave the counter at its maximum
    drive(1'b0, '0, 1'b1, 1'b1);
    cyc();
    for (int i = 0; i < 260; i++) begin
      for (int k = 0; k < N; k++) in_words[k] = $urandom();
      drive(1'b1, SW'($urandom_range(5, 7)), 1'b1, 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    check("sat_err_cnt", 64'(bus.err_cnt), 64'((1 << CNT_W) - 1));
    cyc();

    // Reset in the middle of a stalled stream
    drive(1'b1, SW'(0), 1'b0, 1'b0);
    cyc();
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_err_cnt", 64'(bus.err_cnt), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    check("midrst_out_data", 64'(bus.out_data), 64'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < N; k++) in_words[k] = $urandom();
      drive(1'($urandom_range(0, 3) != 0), SW'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      cyc();
    end

    // Drain the pipeline, with a bounded wait
    drive(1'b0, '0, 1'b1, 1'b0);
    budget = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && budget < 50) begin
      cyc();
      budget++;
    end
    cyc();
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(bus.out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
